// File: rtl/xor_lane_pipe.sv
// xor_lane_pipe: NCH independent lanes, each WIDTH bits wide. Each lane computes
// a^b, ~(a^b) or passes a through, in a DEPTH-stage valid/ready pipeline.
// Bubbles collapse, so an empty stage always accepts a beat even while the
// stages below it are stalled. A saturating beat counter tracks completed
// output handshakes.
// Optional build macro: XOR_LANE_PIPE_PARITY_EN adds out_par, a per-lane
// even-parity bit that travels through the pipeline with the data.
module xor_lane_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_a,
    input  logic [NCH*WIDTH-1:0] in_b,
    input  logic [NCH-1:0]       lane_en,
    input  logic                 invert,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_c,
    output logic [CNTW-1:0]      beat_cnt,
    input  logic                 clr_cnt
`ifdef XOR_LANE_PIPE_PARITY_EN
    ,
    output logic [NCH-1:0]       out_par
`endif
);

    localparam int DW = NCH * WIDTH;

    // Per-lane function: enabled lanes give XOR (or XNOR when invert is set).
    // Disabled lanes pass operand A through unchanged.
    function automatic logic [DW-1:0] lane_fn(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [NCH-1:0] en,
                                              input logic inv);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (en[k])
                r[k*WIDTH +: WIDTH] = inv ? ~(a[k*WIDTH +: WIDTH] ^ b[k*WIDTH +: WIDTH])
                                          :  (a[k*WIDTH +: WIDTH] ^ b[k*WIDTH +: WIDTH]);
            else
                r[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    logic [DEPTH-1:0] vld_p;
    logic [DW-1:0]    data_p [DEPTH];
    logic [DEPTH-1:0] load_p;
    logic [DW-1:0]    lane_res;

    assign lane_res = lane_fn(in_a, in_b, lane_en, invert);

    // Stage i can load when out_ready is high or some stage at or below i is
    // empty. That is the unrolled form of "empty or advancing", and it avoids
    // a combinational loop through the chain.
    always_comb begin
        load_p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load_p[i] = out_ready;
            for (int j = 0; j < DEPTH; j++) begin
                if (j >= i && !vld_p[j])
                    load_p[i] = 1'b1;
            end
        end
    end

    // Input -> stage 0 boundary.
    // Data only moves on a valid beat, so a bubble keeps the old contents and
    // out_c holds while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p[0]  <= 1'b0;
            data_p[0] <= '0;
        end else if (load_p[0]) begin
            vld_p[0] <= in_valid;
            if (in_valid)
                data_p[0] <= lane_res;
        end
    end

    // Stage i-1 -> stage i boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (load_p[i]) begin
                    vld_p[i] <= vld_p[i-1];
                    if (vld_p[i-1])
                        data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign in_ready  = load_p[0];
    assign out_valid = vld_p[DEPTH-1];
    assign out_c     = data_p[DEPTH-1];

`ifdef XOR_LANE_PIPE_PARITY_EN
    // Even-parity bit of each lane result.
    function automatic logic [NCH-1:0] par_fn(input logic [DW-1:0] d);
        logic [NCH-1:0] p;
        for (int k = 0; k < NCH; k++)
            p[k] = ^d[k*WIDTH +: WIDTH];
        return p;
    endfunction

    logic [NCH-1:0] par_p [DEPTH];

    // Parity pipeline: shares the load and valid controls with the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                par_p[i] <= '0;
        end else begin
            if (load_p[0] && in_valid)
                par_p[0] <= par_fn(lane_res);
            for (int i = 1; i < DEPTH; i++) begin
                if (load_p[i] && vld_p[i-1])
                    par_p[i] <= par_p[i-1];
            end
        end
    end

    assign out_par = par_p[DEPTH-1];
`endif

    // Beat counter: a clear takes priority over a handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt <= '0;
        else if (clr_cnt)
            beat_cnt <= '0;
        else if (out_valid && out_ready)
            beat_cnt <= sat_inc(beat_cnt);
    end

endmodule

// File: tb/tb_xor_lane_pipe.sv
`timescale 1ns/1ps
module tb_xor_lane_pipe;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int DEPTH = 2;
    localparam int CNTW  = 4;
    localparam int DW    = NCH * WIDTH;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a, in_b;
    logic [NCH-1:0] lane_en;
    logic          invert;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_c;
    logic [CNTW-1:0] beat_cnt;
    logic          clr_cnt;
`ifdef XOR_LANE_PIPE_PARITY_EN
    logic [NCH-1:0] out_par;
`endif

    xor_lane_pipe #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .lane_en(lane_en), .invert(invert),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .beat_cnt(beat_cnt), .clr_cnt(clr_cnt)
`ifdef XOR_LANE_PIPE_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];
    int            acc_q[$];
    int  mcnt = 0;
    bit  prev_stall = 0;
    logic [DW-1:0] prev_c = '0;
    bit  lat_chk = 0;
    bit  acc;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result: each lane is treated as an integer in 0..255.
    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [NCH-1:0] en, input logic inv);
        int r;
        r = 0;
        for (int k = 0; k < NCH; k++) begin
            int av, bv, res;
            av = (int'(a) >> (WIDTH*k)) % 256;
            bv = (int'(b) >> (WIDTH*k)) % 256;
            if (!en[k])   res = av;
            else if (inv) res = 255 - (av ^ bv);
            else          res = av ^ bv;
            r = r + (res << (WIDTH*k));
        end
        return DW'(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus. A beat that is accepted pushes its expected result.
    task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [NCH-1:0] en, input logic inv,
                        input logic ordy, input logic clr);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; lane_en = en; invert = inv;
        out_ready = ordy; clr_cnt = clr;
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(ref_beat(a, b, en, inv));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    task automatic rnd_beat(input logic v, input logic ordy);
        step(v, DW'($urandom), DW'($urandom), NCH'($urandom), 1'($urandom), ordy, 1'b0);
    endtask

    // Monitor: pops expected results on every output handshake and tracks the counter.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("beat_cnt", 32'(beat_cnt), 32'(mcnt));
                if (prev_stall) begin
                    chk("stall_valid_hold", 32'(out_valid), 32'd1);
                    chk("stall_data_hold", 32'(out_c), 32'(prev_c));
                end
`ifdef XOR_LANE_PIPE_PARITY_EN
                if (out_valid)
                    for (int k = 0; k < NCH; k++)
                        chk("out_par", 32'(out_par[k]), 32'(^out_c[k*WIDTH +: WIDTH]));
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", out_c);
                    end else begin
                        logic [DW-1:0] e;
                        int a0;
                        e  = exp_q.pop_front();
                        a0 = acc_q.pop_front();
                        chk("out_c", 32'(out_c), 32'(e));
                        if (lat_chk) chk("latency", 32'(cyc - a0), 32'(DEPTH));
                    end
                end
                if (clr_cnt) mcnt = 0;
                else if (out_valid && out_ready) mcnt = (mcnt == CMAX) ? CMAX : mcnt + 1;
                prev_stall = out_valid && !out_ready;
                prev_c = out_c;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        logic [DW-1:0] ba[5], bb[5];
        rst_n = 1'b0; in_valid = 0; in_a = '0; in_b = '0; lane_en = '0;
        invert = 0; out_ready = 0; clr_cnt = 0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c", 32'(out_c), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic XOR on both lanes.
        lat_chk = 1;
        step(1'b1, 16'hF00F, 16'hFF0F, 2'b11, 1'b0, 1'b1, 1'b0);
        chk("basic_accept", 32'(acc), 32'd1);
        idle(1'b1);
        chk("basic_early_valid", 32'(out_valid), 32'd0);
        idle(1'b1);
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_out_c", 32'(out_c), 32'h0F00);
        idle(1'b1);
        chk("basic_cnt", 32'(beat_cnt), 32'd1);

        // Mixed modes: lane 0 XNOR, lane 1 pass-through.
        step(1'b1, 16'hAA55, 16'hFF55, 2'b01, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("modes_valid", 32'(out_valid), 32'd1);
        chk("modes_out_c", 32'(out_c), 32'hAAFF);
        idle(1'b1);
        lat_chk = 0;

        // Backpressure: only DEPTH beats fit while the consumer is stalled.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin ba[i] = DW'($urandom); bb[i] = DW'($urandom); end
        j = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ba[j], bb[j], 2'b11, 1'b0, 1'b0, 1'b0);
            if (acc) j++;
        end
        chk("bp_accepted", 32'(j), 32'(DEPTH));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 20 && j < 5; i++) begin
            step(1'b1, ba[j], bb[j], 2'b11, 1'b0, 1'b1, 1'b0);
            if (acc) j++;
        end
        chk("bp_all_sent", 32'(j), 32'd5);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        idle(1'b1);
        chk("bp_cnt", 32'(beat_cnt), 32'd5);

        // Bubbles with a toggling consumer.
        for (int i = 0; i < 40; i++) rnd_beat(1'((i % 2) == 0), 1'(i % 2));
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        chk("bubble_drained", 32'(exp_q.size()), 32'd0);

        // Counter saturation, then a clear coinciding with a handshake.
        lat_chk = 1;
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) rnd_beat(1'b1, 1'b1);
        repeat (DEPTH + 1) idle(1'b1);
        chk("cnt_saturated", 32'(beat_cnt), 32'(CMAX));
        rnd_beat(1'b1, 1'b1);
        idle(1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("clr_hs_valid", 32'(out_valid), 32'd1);
        idle(1'b0);
        chk("clr_wins", 32'(beat_cnt), 32'd0);
        lat_chk = 0;

        // Random traffic.
        for (int i = 0; i < 300; i++) rnd_beat(1'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1'b1);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

`ifdef XOR_LANE_PIPE_PARITY_EN
        step(1'b1, 16'h0007, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("par_lane0", 32'(out_par[0]), 32'd1);
        idle(1'b1);
`endif

        // Asynchronous reset between edges with two beats in flight.
        rnd_beat(1'b1, 1'b0);
        rnd_beat(1'b1, 1'b0);
        @(negedge clk);
        in_valid = 0;
        #3 rst_n = 1'b0;
        #0.5;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        exp_q.delete(); acc_q.delete();
        mcnt = 0; prev_stall = 0;
        #0.5 rst_n = 1'b1;
        repeat (5) idle(1'b1);
        chk("midrst_no_stale", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
